// File: rtl/counter_sequencer.sv
// counter_sequencer: programmable up/down counter controller.
// Sequences q from load_val to limit with one-shot or auto-reload behaviour,
// start/stop/clear commands, a one-cycle tc_pulse and a done level.
// Optional macro PRESCALE_EN adds a tick prescaler driven by presc_div;
// without it every RUN cycle is a tick and presc_div is ignored.
module counter_sequencer #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   limit,
  input  logic               dir,
  input  logic               auto_reload,
  input  logic [PRESC_W-1:0] presc_div,
  output logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic               tc_pulse,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  logic   tick;
  logic   start_cmd;

  // start only acts when stop is not asserted in the same cycle
  assign start_cmd = start & ~stop;

`ifdef PRESCALE_EN
  logic [PRESC_W-1:0] presc;

  assign tick = (presc == presc_div);

  // Prescaler: counts only in RUN, holds in PAUSE, restarts on fresh start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if ((state == IDLE || state == DONE) && start_cmd) begin
      presc <= '0;
    end else if (state == RUN && !stop) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end
`else
  logic unused_presc_div;

  assign tick             = 1'b1;
  assign unused_presc_div = ^presc_div;
`endif

  // Main sequencer: command priority clear > stop > start, tick evaluation in RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      q        <= '0;
      tc_pulse <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (clear) begin
        state <= IDLE;
        q     <= '0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (start_cmd) begin
              state <= RUN;
              q     <= load_val;
            end
          end
          RUN: begin
            if (stop) begin
              state <= PAUSE;
            end else if (tick) begin
              if (q == limit) begin
                tc_pulse <= 1'b1;
                if (auto_reload) begin
                  q <= load_val;
                end else begin
                  state <= DONE;
                end
              end else if (dir) begin
                q <= q + 1'b1;
              end else begin
                q <= q - 1'b1;
              end
            end
          end
          PAUSE: begin
            if (start_cmd) begin
              state <= RUN;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Status levels decoded from the registered state
  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed scenarios plus randomized commands,
// checked every cycle against a behavioural model of the sequencer.
module tb_counter_sequencer;

  localparam int W   = 4;
  localparam int PW  = 4;
  localparam int MOD = 1 << W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, clear, dir, auto_reload;
  logic [W-1:0]  load_val, limit, q;
  logic [PW-1:0] presc_div;
  logic          busy, tc_pulse, done;

  int checks   = 0;
  int failures = 0;

  // behavioural model
  int m_q;
  bit m_counting, m_held, m_finished, m_tc;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .load_val   (load_val),
    .limit      (limit),
    .dir        (dir),
    .auto_reload(auto_reload),
    .presc_div  (presc_div),
    .q          (q),
    .busy       (busy),
    .tc_pulse   (tc_pulse),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_counting = 0; m_held = 0; m_finished = 0; m_tc = 0;
  endtask

  // One clock edge of the specified behaviour, computed from the sampled inputs
  task automatic model_edge();
    bit go;
    go   = start && !stop;
    m_tc = 0;
    if (clear) begin
      model_reset();
    end else if (m_counting) begin
      if (stop) begin
        m_counting = 0; m_held = 1;
      end else if (m_q == int'(limit)) begin
        m_tc = 1;
        if (auto_reload) m_q = int'(load_val);
        else begin m_counting = 0; m_finished = 1; end
      end else if (dir) begin
        m_q = (m_q + 1) % MOD;
      end else begin
        m_q = (m_q + MOD - 1) % MOD;
      end
    end else if (m_held) begin
      if (go) begin m_held = 0; m_counting = 1; end
    end else if (go) begin
      m_finished = 0; m_counting = 1; m_q = int'(load_val);
    end
  endtask

  task automatic compare_all();
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_counting || m_held));
    check("done", 32'(done), 32'(m_finished));
    check("tc_pulse", 32'(tc_pulse), 32'(m_tc));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic cfg(input int lv, input int lim, input bit d, input bit ar);
    load_val    = W'(lv);
    limit       = W'(lim);
    dir         = d;
    auto_reload = ar;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    dir = 1'b1; auto_reload = 1'b0; load_val = '0; limit = '0; presc_div = '0;
    model_reset();
    #12;
    compare_all();
    rst = 1'b1;
    step();

    // one-shot up 0..5
    cfg(0, 5, 1'b1, 1'b0);
    pulse_start();
    repeat (8) step();
    check("oneshot_hold_q", 32'(q), 32'd5);

    // auto-reload down 3..0
    cfg(3, 0, 1'b0, 1'b1);
    pulse_start();
    repeat (10) step();
    pulse_clear();

    // wrap 14,15,0,1 without early tc
    cfg(14, 1, 1'b1, 1'b0);
    pulse_start();
    repeat (6) step();

    // load_val == limit: immediate tc
    cfg(7, 7, 1'b1, 1'b0);
    pulse_start();
    repeat (3) step();

    // pause / resume, then start+stop together in RUN
    cfg(0, 12, 1'b1, 1'b0);
    pulse_start();
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    repeat (5) step();
    check("pause_q", 32'(q), 32'd3);
    pulse_start();
    repeat (2) step();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    repeat (2) step();
    pulse_start();
    repeat (2) step();
    pulse_clear();

    // clear at q=6
    pulse_start();
    repeat (6) step();
    pulse_clear();
    repeat (2) step();

    // asynchronous reset mid-cycle at q=9
    pulse_start();
    repeat (9) step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_rst_q", 32'(q), 32'd0);
    #1 rst = 1'b1;
    repeat (2) step();

    // randomized commands and configuration
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 4) == 0;
      stop  = ($urandom % 10) == 0;
      clear = ($urandom % 40) == 0;
      if (($urandom % 8) == 0) load_val = W'($urandom);
      if (($urandom % 8) == 0) limit = W'($urandom);
      if (($urandom % 12) == 0) dir = ~dir;
      if (($urandom % 12) == 0) auto_reload = ~auto_reload;
      presc_div = PW'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
